fwvexrisc_wb_arbiter: RTL and testbench

Shares one Wishbone initiator port, which drives the SoC interconnect, between up to N Wishbone initiators such as core, DMA and debug. Arbitration is round-robin. A grant is held for the whole `cyc` envelope, so multi-beat bursts from the core bridge are never interleaved with another initiator's accesses. An optional watchdog terminates stalled cycles with an error.

---
 rtl/fwvexrisc_wb_arb_pkg.sv | 14 +
 rtl/fwvexrisc_rr_pick.sv | 36 +++
 rtl/fwvexrisc_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_fwvexrisc_wb_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwvexrisc_wb_arb_pkg.sv
// Shared types and helpers for the fwvexrisc Wishbone round-robin arbiter.
package fwvexrisc_wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Index width for an N-way selection; never narrower than one bit.
  function automatic int arb_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fwvexrisc_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx, wrapping modulo N_INIT.
module fwvexrisc_rr_pick
  import fwvexrisc_wb_arb_pkg::*;
#(
  parameter int   N_INIT = 2,
  localparam int  IDX_W  = arb_idx_w(N_INIT)
) (
  input  logic [N_INIT-1:0] req,
  input  logic [IDX_W-1:0]  last_idx,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    for (int off = N_INIT; off >= 1; off--) begin
      cand = {1'b0, last_idx} + CW'(off);
      if (cand >= CW'(N_INIT)) begin
        cand = cand - CW'(N_INIT);
      end
      if (req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fwvexrisc_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one downstream initiator port; grant held for the cyc envelope.
// Optional stall watchdog enabled by defining FWVEXRISC_WB_ARB_TIMEOUT_EN.
module fwvexrisc_wb_arbiter
  import fwvexrisc_wb_arb_pkg::*;
#(
  parameter int           N_INIT         = 2,
  parameter int           ADDR_W         = 32,
  parameter int           DATA_W         = 32,
  parameter int unsigned  TIMEOUT_CYCLES = 255,
  localparam int          SEL_W          = DATA_W / 8,
  localparam int          IDX_W          = arb_idx_w(N_INIT)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_INIT*ADDR_W-1:0]   t_adr,
  input  logic [N_INIT*DATA_W-1:0]   t_dat_w,
  input  logic [N_INIT*SEL_W-1:0]    t_sel,
  input  logic [N_INIT-1:0]          t_cyc,
  input  logic [N_INIT-1:0]          t_stb,
  input  logic [N_INIT-1:0]          t_we,
  output logic [DATA_W-1:0]          t_dat_r,
  output logic [N_INIT-1:0]          t_ack,
  output logic [N_INIT-1:0]          t_err,
  output logic [ADDR_W-1:0]          i_adr,
  output logic [DATA_W-1:0]          i_dat_w,
  output logic [SEL_W-1:0]           i_sel,
  output logic                       i_cyc,
  output logic                       i_stb,
  output logic                       i_we,
  input  logic [DATA_W-1:0]          i_dat_r,
  input  logic                       i_ack,
  input  logic                       i_err,
  output logic [IDX_W-1:0]           gnt_idx,
  output logic                       busy,
  output logic                       timeout
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [N_INIT-1:0] req;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              own_cyc;
  logic              own_stb;
  logic              wd_fire;

  assign req = t_cyc & t_stb;

  fwvexrisc_rr_pick #(
    .N_INIT   (N_INIT)
  ) u_pick (
    .req      (req),
    .last_idx (last_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(N_INIT - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state plus owner mux; in IDLE every downstream output and termination stays 0.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    i_adr   = '0;
    i_dat_w = '0;
    i_sel   = '0;
    i_we    = 1'b0;
    t_ack   = '0;
    t_err   = '0;

    if (state_q == ARB_OWN) begin
      for (int k = 0; k < N_INIT; k++) begin
        if (gnt_q == IDX_W'(k)) begin
          own_cyc  = t_cyc[k];
          own_stb  = t_stb[k];
          i_adr    = t_adr[k*ADDR_W +: ADDR_W];
          i_dat_w  = t_dat_w[k*DATA_W +: DATA_W];
          i_sel    = t_sel[k*SEL_W +: SEL_W];
          i_we     = t_we[k];
          t_ack[k] = i_ack;
          t_err[k] = i_err | wd_fire;
        end
      end
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_OWN;
          gnt_d   = pick_idx;
          last_d  = pick_idx;
        end
      end
      ARB_OWN: begin
        if (!own_cyc) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    i_cyc = own_cyc;
    i_stb = own_stb & ~wd_fire;
  end

  assign busy    = (state_q == ARB_OWN);
  assign gnt_idx = gnt_q;
  // Read data is gated only while reset is held, so nothing leaks upstream during reset.
  assign t_dat_r = reset ? '0 : i_dat_r;

`ifdef FWVEXRISC_WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wd_fire = (state_q == ARB_OWN) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign timeout = wd_fire;

  // Counts consecutive strobed cycles without termination.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_q != ARB_OWN) || !own_stb || i_ack || i_err || wd_fire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign wd_fire            = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_fwvexrisc_wb_arbiter.sv
// Self-checking bench for fwvexrisc_wb_arbiter: vector table, corner sequences, randomized model check.
module tb_fwvexrisc_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = 2;
  localparam int TO = 16;
  localparam int NV = 25;

  typedef struct {
    logic [N-1:0]  cyc;
    logic [N-1:0]  stb;
    logic [N-1:0]  we;
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
    logic          e_cyc;
    logic          e_stb;
    logic          e_we;
    logic [AW-1:0] e_adr;
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_err;
    logic          e_busy;
    logic [IW-1:0] e_gnt;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] adr [N];
  logic [DW-1:0] dw  [N];
  logic [SW-1:0] sel [N];
  logic [N-1:0]  cyc, stb, we;
  logic [N*AW-1:0] t_adr;
  logic [N*DW-1:0] t_dat_w;
  logic [N*SW-1:0] t_sel;
  logic [DW-1:0] t_dat_r;
  logic [N-1:0]  t_ack, t_err;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_dat_w;
  logic [SW-1:0] i_sel;
  logic          i_cyc, i_stb, i_we;
  logic [DW-1:0] i_dat_r;
  logic          i_ack, i_err;
  logic [IW-1:0] gnt_idx;
  logic          busy, timeout;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tv [NV];

  assign t_adr   = {adr[2], adr[1], adr[0]};
  assign t_dat_w = {dw[2], dw[1], dw[0]};
  assign t_sel   = {sel[2], sel[1], sel[0]};

  fwvexrisc_wb_arbiter #(
    .N_INIT         (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .t_adr   (t_adr),
    .t_dat_w (t_dat_w),
    .t_sel   (t_sel),
    .t_cyc   (cyc),
    .t_stb   (stb),
    .t_we    (we),
    .t_dat_r (t_dat_r),
    .t_ack   (t_ack),
    .t_err   (t_err),
    .i_adr   (i_adr),
    .i_dat_w (i_dat_w),
    .i_sel   (i_sel),
    .i_cyc   (i_cyc),
    .i_stb   (i_stb),
    .i_we    (i_we),
    .i_dat_r (i_dat_r),
    .i_ack   (i_ack),
    .i_err   (i_err),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_bus(input string tag, input logic e_cyc, input logic e_stb, input logic e_we,
                         input logic [AW-1:0] e_adr, input logic [DW-1:0] e_dw, input logic [SW-1:0] e_sel,
                         input logic [N-1:0] e_ack, input logic [N-1:0] e_err, input logic e_busy,
                         input logic [IW-1:0] e_gnt, input logic [DW-1:0] e_dr);
    check({tag, ".i_cyc"},   64'(i_cyc),   64'(e_cyc));
    check({tag, ".i_stb"},   64'(i_stb),   64'(e_stb));
    check({tag, ".i_we"},    64'(i_we),    64'(e_we));
    check({tag, ".i_adr"},   64'(i_adr),   64'(e_adr));
    check({tag, ".i_dat_w"}, 64'(i_dat_w), 64'(e_dw));
    check({tag, ".i_sel"},   64'(i_sel),   64'(e_sel));
    check({tag, ".t_ack"},   64'(t_ack),   64'(e_ack));
    check({tag, ".t_err"},   64'(t_err),   64'(e_err));
    check({tag, ".busy"},    64'(busy),    64'(e_busy));
    check({tag, ".t_dat_r"}, 64'(t_dat_r), 64'(e_dr));
    if (e_busy) begin
      check({tag, ".gnt_idx"}, 64'(gnt_idx), 64'(e_gnt));
    end
  endtask

  task automatic fill_vectors();
    //          cyc     stb     we      ack   err   dat            e_cyc e_stb e_we  e_adr       e_ack   e_err   busy  gnt
    tv[0]  = '{3'b010, 3'b010, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[1]  = '{3'b010, 3'b010, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h1000, 3'b000, 3'b000, 1'b1, 2'd1};
    tv[2]  = '{3'b010, 3'b010, 3'b100, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h1000, 3'b010, 3'b000, 1'b1, 2'd1};
    tv[3]  = '{3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h1000, 3'b000, 3'b000, 1'b1, 2'd1};
    tv[4]  = '{3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[5]  = '{3'b011, 3'b011, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[6]  = '{3'b010, 3'b010, 3'b100, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h2000, 3'b001, 3'b000, 1'b1, 2'd0};
    tv[7]  = '{3'b011, 3'b011, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[8]  = '{3'b011, 3'b011, 3'b100, 1'b1, 1'b0, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 32'h1000, 3'b010, 3'b000, 1'b1, 2'd1};
    tv[9]  = '{3'b001, 3'b001, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h1000, 3'b000, 3'b000, 1'b1, 2'd1};
    tv[10] = '{3'b001, 3'b001, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[11] = '{3'b001, 3'b001, 3'b100, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h2000, 3'b000, 3'b001, 1'b1, 2'd0};
    tv[12] = '{3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h2000, 3'b000, 3'b000, 1'b1, 2'd0};
    tv[13] = '{3'b000, 3'b000, 3'b100, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[14] = '{3'b100, 3'b100, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[15] = '{3'b100, 3'b100, 3'b100, 1'b1, 1'b0, 32'h3333_3333, 1'b1, 1'b1, 1'b1, 32'h3000, 3'b100, 3'b000, 1'b1, 2'd2};
    tv[16] = '{3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h3000, 3'b000, 3'b000, 1'b1, 2'd2};
    tv[17] = '{3'b111, 3'b111, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[18] = '{3'b110, 3'b110, 3'b100, 1'b1, 1'b0, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 32'h2000, 3'b001, 3'b000, 1'b1, 2'd0};
    tv[19] = '{3'b111, 3'b111, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[20] = '{3'b111, 3'b111, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h1000, 3'b000, 3'b000, 1'b1, 2'd1};
    tv[21] = '{3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h1000, 3'b000, 3'b000, 1'b1, 2'd1};
    tv[22] = '{3'b001, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[23] = '{3'b001, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
    tv[24] = '{3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000, 3'b000, 3'b000, 1'b0, 2'd0};
  endtask

  initial begin
    int            m_own;
    int            m_last;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dw;
    logic [SW-1:0] e_sel;
    logic [N-1:0]  e_ack, e_err;
    logic [IW-1:0] e_gnt;
    logic          found;

    fill_vectors();
    adr[0] = 32'h2000; adr[1] = 32'h1000; adr[2] = 32'h3000;
    for (int k = 0; k < N; k++) begin
      dw[k]  = 32'hA0A0_0000 | 32'(k);
      sel[k] = SW'(1 << k);
    end

    // Reset state: requests and responses present while reset is held.
    cyc = 3'b111; stb = 3'b111; we = 3'b111;
    i_ack = 1'b1; i_err = 1'b1; i_dat_r = 32'hFFFF_FFFF;
    @(negedge clock);
    #1;
    chk_bus("reset", 1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000, 3'b000, 1'b0, 2'd0, 32'h0);
    check("reset.gnt_idx", 64'(gnt_idx), 64'd0);
    check("reset.timeout", 64'(timeout), 64'd0);
    reset = 1'b0;
    cyc = '0; stb = '0; we = '0; i_ack = 1'b0; i_err = 1'b0; i_dat_r = '0;
    tick();

    // Vector table: single read, alternating owners, same-cycle drop, idle acks, cyc-without-stb.
    for (int r = 0; r < NV; r++) begin
      cyc = tv[r].cyc; stb = tv[r].stb; we = tv[r].we;
      i_ack = tv[r].ack; i_err = tv[r].err; i_dat_r = tv[r].dat;
      #1;
      chk_bus($sformatf("vec%0d", r), tv[r].e_cyc, tv[r].e_stb, tv[r].e_we, tv[r].e_adr,
              tv[r].e_busy ? dw[tv[r].e_gnt] : '0, tv[r].e_busy ? sel[tv[r].e_gnt] : '0,
              tv[r].e_ack, tv[r].e_err, tv[r].e_busy, tv[r].e_gnt, tv[r].dat);
      tick();
    end

    // Burst lock: initiator 0 runs 8 beats at 0x2000 while initiator 1 waits.
    cyc = 3'b011; stb = 3'b011; we = '0; i_ack = 1'b0; i_err = 1'b0; i_dat_r = '0;
    #1;
    check("burst.idle_busy", 64'(busy), 64'd0);
    tick();
    for (int b = 0; b < 8; b++) begin
      adr[0] = 32'h2000 + 32'(4 * b);
      i_ack  = 1'b1;
      #1;
      check($sformatf("burst.b%0d.i_adr", b), 64'(i_adr), 64'(32'h2000 + 32'(4 * b)));
      check($sformatf("burst.b%0d.t_ack", b), 64'(t_ack), 64'(3'b001));
      check($sformatf("burst.b%0d.gnt", b), 64'(gnt_idx), 64'd0);
      tick();
    end
    cyc = 3'b010; stb = 3'b010; i_ack = 1'b0;
    #1;
    check("burst.end.i_cyc", 64'(i_cyc), 64'd0);
    check("burst.end.t_ack", 64'(t_ack), 64'(3'b000));
    tick();
    #1;
    check("burst.gap.busy", 64'(busy), 64'd0);
    tick();
    #1;
    check("burst.next.busy", 64'(busy), 64'd1);
    check("burst.next.gnt", 64'(gnt_idx), 64'd1);
    check("burst.next.i_adr", 64'(i_adr), 64'(32'h1000));
    tick();

    // Async reset in the middle of initiator 1's burst while all three request.
    cyc = 3'b111; stb = 3'b111;
    for (int b = 0; b < 3; b++) begin
      adr[1] = 32'h1000 + 32'(4 * b);
      i_ack  = 1'b1;
      #1;
      check($sformatf("rst.b%0d.t_ack", b), 64'(t_ack), 64'(3'b010));
      tick();
    end
    i_ack = 1'b1; i_dat_r = 32'hCAFE_F00D;
    #2;
    reset = 1'b1;
    #1;
    check("rst.mid.i_cyc", 64'(i_cyc), 64'd0);
    check("rst.mid.busy", 64'(busy), 64'd0);
    check("rst.mid.t_ack", 64'(t_ack), 64'(3'b000));
    check("rst.mid.i_adr", 64'(i_adr), 64'd0);
    check("rst.mid.t_dat_r", 64'(t_dat_r), 64'd0);
    tick();
    reset = 1'b0; i_ack = 1'b0;
    #1;
    check("rst.after.busy", 64'(busy), 64'd0);
    check("rst.after.t_dat_r", 64'(t_dat_r), 64'(32'hCAFE_F00D));
    tick();
    #1;
    check("rst.first.busy", 64'(busy), 64'd1);
    check("rst.first.gnt", 64'(gnt_idx), 64'd0);
    cyc = '0; stb = '0;
    tick();

    // Stalled target on initiator 2: watchdog behaviour depends on the build.
    cyc = 3'b100; stb = 3'b100; i_ack = 1'b0; i_err = 1'b0;
    #1;
    check("wd.idle.busy", 64'(busy), 64'd0);
    tick();
    for (int k = 1; k <= TO; k++) begin
      #1;
      check($sformatf("wd.c%0d.i_stb", k), 64'(i_stb), 64'd1);
      check($sformatf("wd.c%0d.t_err", k), 64'(t_err), 64'(3'b000));
      check($sformatf("wd.c%0d.timeout", k), 64'(timeout), 64'd0);
      tick();
    end
    #1;
`ifdef FWVEXRISC_WB_ARB_TIMEOUT_EN
    check("wd.fire.t_err", 64'(t_err), 64'(3'b100));
    check("wd.fire.timeout", 64'(timeout), 64'd1);
    check("wd.fire.i_stb", 64'(i_stb), 64'd0);
    cyc = '0; stb = '0;
    tick();
`else
    for (int k = TO + 1; k <= TO + 20; k++) begin
      check($sformatf("wd.hold%0d.t_err", k), 64'(t_err), 64'(3'b000));
      check($sformatf("wd.hold%0d.timeout", k), 64'(timeout), 64'd0);
      check($sformatf("wd.hold%0d.busy", k), 64'(busy), 64'd1);
      tick();
      #1;
    end
    cyc = '0; stb = '0;
    tick();
`endif
    cyc = 3'b010; stb = 3'b010;
    #1;
    check("wd.next.idle", 64'(busy), 64'd0);
    tick();
    #1;
    check("wd.next.busy", 64'(busy), 64'd1);
    check("wd.next.gnt", 64'(gnt_idx), 64'd1);
    check("wd.next.t_err", 64'(t_err), 64'(3'b000));
    cyc = '0; stb = '0;
    tick();

    // Randomized traffic against a behavioural owner/last model.
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    m_own  = -1;
    m_last = N - 1;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        cyc[k] = ($urandom_range(0, 3) != 0);
        stb[k] = cyc[k] ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        we[k]  = 1'($urandom());
        adr[k] = $urandom();
        dw[k]  = $urandom();
        sel[k] = SW'($urandom());
      end
      i_ack   = 1'($urandom());
      i_err   = ($urandom_range(0, 7) == 0);
      i_dat_r = $urandom();

      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dw = '0; e_sel = '0;
      e_ack = '0; e_err = '0; e_gnt = '0;
      if (m_own >= 0) begin
        e_cyc = cyc[m_own];
        e_stb = stb[m_own];
        e_we  = we[m_own];
        e_adr = adr[m_own];
        e_dw  = dw[m_own];
        e_sel = sel[m_own];
        e_ack = i_ack ? N'(1 << m_own) : '0;
        e_err = i_err ? N'(1 << m_own) : '0;
        e_gnt = IW'(m_own);
      end
      #1;
      chk_bus($sformatf("rnd%0d", c), e_cyc, e_stb, e_we, e_adr, e_dw, e_sel,
              e_ack, e_err, (m_own >= 0), e_gnt, i_dat_r);

      if (m_own < 0) begin
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
          int cand;
          cand = (m_last + off) % N;
          if (!found && cyc[cand] && stb[cand]) begin
            found  = 1'b1;
            m_own  = cand;
            m_last = cand;
          end
        end
      end else if (!cyc[m_own]) begin
        m_own = -1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
